// File: rtl/rv_pkg.sv
// Shared core definitions: register index widths, data width and the register-file write-port payload.
package rv_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 32;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
        logic                 we;
    } wr_port_t;

endpackage

// File: rtl/wb_ldq.sv
// Load-response FIFO: synchronous push/pop, registered occupancy count, head entry exposed directly.
module wb_ldq
    import rv_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned DW    = XLEN,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  logic [REG_IDX_W-1:0] push_rd_i,
    input  logic [DW-1:0]        push_data_i,
    input  logic                 pop_i,
    output logic [CNT_W-1:0]     count_o,
    output logic [REG_IDX_W-1:0] head_rd_o,
    output logic [DW-1:0]        head_data_o
);

    logic [REG_IDX_W-1:0] mem_rd_q   [DEPTH];
    logic [DW-1:0]        mem_data_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_rd_q[wr_ptr_q]   <= push_rd_i;
            mem_data_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o     = count_q;
    assign head_rd_o   = mem_rd_q[rd_ptr_q];
    assign head_data_o = mem_data_q[rd_ptr_q];

endmodule

// File: rtl/wb_sched.sv
// Write-back scheduler: merges ALU results and load responses onto the single register-file
// write port, queues colliding loads, and tracks in-flight loads in a per-register busy scoreboard.
module wb_sched
    import rv_pkg::*;
#(
    parameter  int unsigned XLEN      = rv_pkg::XLEN,
    parameter  int unsigned LDQ_DEPTH = 2,
    localparam int unsigned CNT_W     = $clog2(LDQ_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iss_valid,
    input  logic [REG_IDX_W-1:0] iss_rd,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 ld_valid,
    input  logic [REG_IDX_W-1:0] ld_rd,
    input  logic [XLEN-1:0]      ld_data,
    output logic                 ld_ready,
    input  logic [REG_IDX_W-1:0] chk_rs1,
    input  logic [REG_IDX_W-1:0] chk_rs2,
    input  logic [REG_IDX_W-1:0] chk_rd,
    output logic                 busy_rs1,
    output logic                 busy_rs2,
    output logic                 busy_rd,
    output logic [REG_IDX_W-1:0] rd,
    output logic [XLEN-1:0]      writedata,
    output logic                 reg_write,
    output logic                 proto_err
);

    logic [CNT_W-1:0]     ldq_count;
    logic [REG_IDX_W-1:0] ldq_head_rd;
    logic [XLEN-1:0]      ldq_head_data;

    logic alu_win;
    logic ld_accept;
    logic ldq_nonempty;
    logic ld_bypass;
    logic ldq_push;
    logic ldq_pop;

    logic [NUM_REGS-1:0] busy_q, busy_d;
    wr_port_t            wp_q, wp_d;
    logic                proto_err_q, proto_err_d;

    wb_ldq #(
        .DEPTH (LDQ_DEPTH),
        .DW    (XLEN)
    ) u_ldq (
        .clk         (clk),
        .reset       (reset),
        .push_i      (ldq_push),
        .push_rd_i   (ld_rd),
        .push_data_i (ld_data),
        .pop_i       (ldq_pop),
        .count_o     (ldq_count),
        .head_rd_o   (ldq_head_rd),
        .head_data_o (ldq_head_data)
    );

    // Ready depends only on the registered count, never on this cycle's pop.
    assign ld_ready = (ldq_count < CNT_W'(LDQ_DEPTH));

    // Slot arbitration: ALU, then queued load, then bypass of a fresh load.
    always_comb begin
        alu_win      = alu_valid && (alu_rd != REG_ZERO);
        ld_accept    = ld_valid && ld_ready;
        ldq_nonempty = (ldq_count != '0);
        ldq_pop      = !alu_win && ldq_nonempty;
        ld_bypass    = !alu_win && !ldq_nonempty && ld_accept && (ld_rd != REG_ZERO);
        ldq_push     = ld_accept && (ld_rd != REG_ZERO) && !ld_bypass;
    end

    always_comb begin
        wp_d    = wp_q;
        wp_d.we = 1'b0;
        if (alu_win) begin
            wp_d = '{rd: alu_rd, data: alu_data, we: 1'b1};
        end else if (ldq_pop) begin
            wp_d = '{rd: ldq_head_rd, data: ldq_head_data, we: 1'b1};
        end else if (ld_bypass) begin
            wp_d = '{rd: ld_rd, data: ld_data, we: 1'b1};
        end
    end

    // Clear on load write-back first so a same-cycle issue to that register re-sets it.
    always_comb begin
        busy_d = busy_q;
        if (ldq_pop) begin
            busy_d[ldq_head_rd] = 1'b0;
        end else if (ld_bypass) begin
            busy_d[ld_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != REG_ZERO)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        proto_err_d = proto_err_q
                    | (iss_valid && (iss_rd != REG_ZERO) && busy_q[iss_rd])
                    | (alu_win && busy_q[alu_rd])
                    | (ld_valid && !busy_q[ld_rd]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q      <= '0;
            wp_q        <= '0;
            proto_err_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            wp_q        <= wp_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign busy_rs1  = busy_q[chk_rs1];
    assign busy_rs2  = busy_q[chk_rs2];
    assign busy_rd   = busy_q[chk_rd];
    assign rd        = wp_q.rd;
    assign writedata = wp_q.data;
    assign reg_write = wp_q.we;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_wb_sched.sv
// Directed bench for wb_sched: reset, ALU/load write-back ordering, backpressure and scoreboard hazards.
module tb_wb_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [63:0] ld_data;
    logic        ld_ready;
    logic [4:0]  chk_rs1, chk_rs2, chk_rd;
    logic        busy_rs1, busy_rs2, busy_rd;
    logic [4:0]  rd;
    logic [63:0] writedata;
    logic        reg_write;
    logic        proto_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_sched dut (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .chk_rd    (chk_rd),
        .busy_rs1  (busy_rs1),
        .busy_rs2  (busy_rs2),
        .busy_rd   (busy_rd),
        .rd        (rd),
        .writedata (writedata),
        .reg_write (reg_write),
        .proto_err (proto_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0; iss_rd = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_write(input string tag, input logic [4:0] e_rd, input logic [63:0] e_data);
        check({tag, "_we"}, 64'(reg_write), 64'd1);
        check({tag, "_rd"}, 64'(rd), 64'(e_rd));
        check({tag, "_data"}, writedata, e_data);
    endtask

    task automatic issue(input logic [4:0] r);
        iss_valid = 1'b1; iss_rd = r;
        step();
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    initial begin
        idle_inputs();
        chk_rs1 = 5'd0; chk_rs2 = 5'd1; chk_rd = 5'd31;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;

        // Reset state
        check("rst_we", 64'(reg_write), 64'd0);
        check("rst_rd", 64'(rd), 64'd0);
        check("rst_data", writedata, 64'd0);
        check("rst_ready", 64'(ld_ready), 64'd1);
        check("rst_perr", 64'(proto_err), 64'd0);
        check("rst_busy", {61'd0, busy_rs1, busy_rs2, busy_rd}, 64'd0);

        // Lone ALU write, then idle holds rd/data
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        step();
        check_write("alu", 5'd5, 64'h1234);
        idle_inputs();
        step();
        check("alu_idle_we", 64'(reg_write), 64'd0);
        check("alu_idle_rd", 64'(rd), 64'd5);
        check("alu_idle_data", writedata, 64'h1234);

        // Uncontended load lifecycle
        chk_rd = 5'd8;
        issue(5'd8);
        check("ld8_busy_set", 64'(busy_rd), 64'd1);
        step();
        ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 64'hDEAD;
        step();
        idle_inputs();
        check_write("ld8", 5'd8, 64'hDEAD);
        check("ld8_busy_clr", 64'(busy_rd), 64'd0);
        check("ld8_perr", 64'(proto_err), 64'd0);

        // ALU and load collide: ALU first, queued load one cycle later
        chk_rd = 5'd9;
        issue(5'd9);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
        ld_valid  = 1'b1; ld_rd  = 5'd9; ld_data  = 64'h99;
        step();
        idle_inputs();
        check_write("col_alu", 5'd3, 64'h33);
        check("col_cnt1", 64'(dut.u_ldq.count_q), 64'd1);
        check("col_busy9_held", 64'(busy_rd), 64'd1);
        step();
        check_write("col_ld", 5'd9, 64'h99);
        check("col_cnt0", 64'(dut.u_ldq.count_q), 64'd0);
        check("col_busy9_clr", 64'(busy_rd), 64'd0);

        // Backpressure: three ALU writes block the port while loads 10, 11, 12 arrive
        issue(5'd10); issue(5'd11); issue(5'd12);
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'hA1;
        ld_valid  = 1'b1; ld_rd  = 5'd10; ld_data = 64'h100;
        step();
        check_write("bp_a1", 5'd1, 64'hA1);
        check("bp_ready1", 64'(ld_ready), 64'd1);
        alu_rd = 5'd2; alu_data = 64'hA2;
        ld_rd  = 5'd11; ld_data = 64'h110;
        step();
        check_write("bp_a2", 5'd2, 64'hA2);
        check("bp_ready_full", 64'(ld_ready), 64'd0);
        alu_rd = 5'd4; alu_data = 64'hA4;
        ld_rd  = 5'd12; ld_data = 64'h120;
        step();
        check_write("bp_a4", 5'd4, 64'hA4);
        check("bp_still_full", 64'(ld_ready), 64'd0);
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        step();
        check_write("bp_w10", 5'd10, 64'h100);
        check("bp_ready_again", 64'(ld_ready), 64'd1);
        step();
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        check_write("bp_w11", 5'd11, 64'h110);
        step();
        check_write("bp_w12", 5'd12, 64'h120);
        step();
        check("bp_drained_we", 64'(reg_write), 64'd0);
        chk_rs1 = 5'd10; chk_rs2 = 5'd11; chk_rd = 5'd12;
        check("bp_busy_clr", {61'd0, busy_rs1, busy_rs2, busy_rd}, 64'd0);
        check("bp_perr", 64'(proto_err), 64'd0);

        // x0 hazards and WAW detection
        chk_rs1 = 5'd0;
        issue(5'd0);
        check("x0_busy", 64'(busy_rs1), 64'd0);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFF;
        step();
        idle_inputs();
        check("x0_alu_we", 64'(reg_write), 64'd0);
        check("x0_perr", 64'(proto_err), 64'd0);
        chk_rd = 5'd7;
        issue(5'd7);
        check("waw_busy7", 64'(busy_rd), 64'd1);
        check("waw_perr_pre", 64'(proto_err), 64'd0);
        issue(5'd7);
        check("waw_perr", 64'(proto_err), 64'd1);
        step(); step();
        check("waw_perr_sticky", 64'(proto_err), 64'd1);

        // Reset mid-stream with two queued loads
        issue(5'd13); issue(5'd14);
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'hB1;
        ld_valid  = 1'b1; ld_rd  = 5'd13; ld_data = 64'h130;
        step();
        alu_rd = 5'd2; alu_data = 64'hB2;
        ld_rd  = 5'd14; ld_data = 64'h140;
        step();
        idle_inputs();
        check("mid_full", 64'(ld_ready), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_rs1 = 5'd13; chk_rs2 = 5'd14; chk_rd = 5'd7;
        check("mid_cnt", 64'(dut.u_ldq.count_q), 64'd0);
        check("mid_ready", 64'(ld_ready), 64'd1);
        check("mid_we", 64'(reg_write), 64'd0);
        check("mid_rd", 64'(rd), 64'd0);
        check("mid_busy", {61'd0, busy_rs1, busy_rs2, busy_rd}, 64'd0);
        check("mid_perr", 64'(proto_err), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_stale_we", 64'(reg_write), 64'd0);
        end

        // Same-cycle clear (bypass write of 15) and re-issue of 15: set wins
        chk_rd = 5'd15;
        issue(5'd15);
        iss_valid = 1'b1; iss_rd = 5'd15;
        ld_valid  = 1'b1; ld_rd  = 5'd15; ld_data = 64'h150;
        step();
        idle_inputs();
        check_write("setclr", 5'd15, 64'h150);
        check("setclr_busy", 64'(busy_rd), 64'd1);
        check("setclr_perr", 64'(proto_err), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
